// File: rtl/design_example_pkg.sv
// Shared definitions for the design-example driver: FSM encoding and the
// result a nominal run of the design example produces.
package design_example_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_CLR = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Final A/E and latency of a run started from an idle design example
  localparam logic [3:0] A_DONE  = 4'b1101;
  localparam int         LAT_NOM = 16;

endpackage

// File: rtl/design_example_driver_sat_counter.sv
// Saturating up-counter with synchronous clear. o_cnt_inc is the value the
// counter takes on its next enabled edge, so callers can capture a count
// that includes the current cycle.
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 64
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_cnt_inc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // Saturating increment: holds at MAX instead of wrapping
  always_comb begin
    o_cnt_inc = (r_cnt == MAX_V) ? r_cnt : r_cnt + 1'b1;
  end

  // Count register; clear has priority over enable
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_cnt_inc;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/design_example_driver.sv
// Sole Start source for the design example: takes one command at a time,
// pulses Start, waits for F to clear then set, and returns A/E plus the
// run latency (or a timeout flag) on a valid/ready response port.
module design_example_driver
  import design_example_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int LAT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             Start,
  input  logic [3:0]       A_in,
  input  logic             E_in,
  input  logic             F_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_A,
  output logic             rsp_E,
  output logic [LAT_W-1:0] rsp_lat,
  output logic             rsp_timeout,
  output logic [7:0]       run_count
);

  localparam logic [LAT_W-1:0] TMO_V = LAT_W'(TIMEOUT);

  state_t             r_state, w_state_nxt;
  logic               r_start;
  logic [3:0]         r_rsp_A;
  logic               r_rsp_E;
  logic [LAT_W-1:0]   r_rsp_lat;
  logic               r_rsp_timeout;
  logic [7:0]         r_run_count;

  logic               w_accept;
  logic               w_cnt_en;
  logic               w_waiting;
  logic               w_complete;
  logic               w_tmo;
  logic [LAT_W-1:0]   w_cnt;
  logic [LAT_W-1:0]   w_cnt_inc;

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_waiting  = (r_state == S_WAIT_CLR) || (r_state == S_RUN);
  assign w_cnt_en   = (r_state == S_START) || w_waiting;
  assign w_complete = (r_state == S_RUN) && F_in;
  assign w_tmo      = w_waiting && (w_cnt == TMO_V);

  // Latency counter saturates at TIMEOUT, so a completion landing on the
  // timeout cycle still reports TIMEOUT rather than TIMEOUT+1.
  sat_counter #(
    .W   (LAT_W),
    .MAX (TIMEOUT)
  ) u_lat_cnt (
    .clock     (clock),
    .reset_b   (reset_b),
    .i_clr     (w_accept),
    .i_en      (w_cnt_en),
    .o_cnt     (w_cnt),
    .o_cnt_inc (w_cnt_inc)
  );

  // Next-state decode; RUN completion beats timeout, while in WAIT_CLR the
  // timeout beats the move to RUN since nothing has completed yet.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (cmd_valid) w_state_nxt = S_START;
      S_START:    w_state_nxt = S_WAIT_CLR;
      S_WAIT_CLR: begin
        if (w_tmo)      w_state_nxt = S_DONE;
        else if (!F_in) w_state_nxt = S_RUN;
      end
      S_RUN:      if (F_in || w_tmo) w_state_nxt = S_DONE;
      S_DONE:     if (rsp_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // State register and the registered Start pulse (high only in START)
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= (w_state_nxt == S_START);
    end
  end

  // Result capture; latency counts START through the completing cycle
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_rsp_A       <= '0;
      r_rsp_E       <= 1'b0;
      r_rsp_lat     <= '0;
      r_rsp_timeout <= 1'b0;
    end else if (w_complete) begin
      r_rsp_A       <= A_in;
      r_rsp_E       <= E_in;
      r_rsp_lat     <= w_cnt_inc;
      r_rsp_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_rsp_A       <= A_in;
      r_rsp_E       <= E_in;
      r_rsp_lat     <= TMO_V;
      r_rsp_timeout <= 1'b1;
    end
  end

  // Completed-response counter, bumped on the response handshake
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b)                             r_run_count <= '0;
    else if ((r_state == S_DONE) && rsp_ready) r_run_count <= r_run_count + 8'd1;
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_DONE);
  assign Start       = r_start;
  assign rsp_A       = r_rsp_A;
  assign rsp_E       = r_rsp_E;
  assign rsp_lat     = r_rsp_lat;
  assign rsp_timeout = r_rsp_timeout;
  assign run_count   = r_run_count;

endmodule
